// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and result flags.
package seq_alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_XOR = 4'd2,
    OP_SHL = 4'd3,
    OP_SHR = 4'd4,
    OP_MOD = 4'd5,
    OP_ADD = 4'd6,
    OP_SUB = 4'd7,
    OP_MUL = 4'd8,
    OP_DIV = 4'd9
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic neg;
    logic zero;
    logic err;
  } flags_t;

  // MUL always iterates; DIV/MOD iterate only when the divisor is non-zero.
  function automatic logic is_iterative(input logic [OP_W-1:0] op, input logic b_zero);
    return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && !b_zero);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// N-step shift-add multiplier / restoring divider. hi_c/lo_c present the value
// after the current step so the owner can capture the final step directly.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         is_div,
  input  logic         step,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] hi_c,
  output logic [N-1:0] lo_c,
  output logic         last_c
);

  localparam int unsigned CW = $clog2(N);

  logic [N-1:0]  hi_q;
  logic [N-1:0]  lo_q;
  logic [N-1:0]  dvs_q;
  logic          div_q;
  logic [CW-1:0] cnt_q;

  logic [N:0]    sum;
  logic [N:0]    shifted;
  logic          ge;
  logic [N-1:0]  rem;
  logic [N-1:0]  quo;

  // One iteration: multiply uses {hi,lo} as product/multiplier, divide as remainder/quotient.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : (N+1)'(0));
    shifted = {hi_q, lo_q[N-1]};
    ge      = (shifted >= {1'b0, dvs_q});
    rem     = ge ? (shifted[N-1:0] - dvs_q) : shifted[N-1:0];
    quo     = {lo_q[N-2:0], ge};
    if (div_q) begin
      hi_c = rem;
      lo_c = quo;
    end else begin
      hi_c = sum[N:1];
      lo_c = {sum[0], lo_q[N-1:1]};
    end
    last_c = step && (cnt_q == CW'(N-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      dvs_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= a;
      dvs_q <= b;
      div_q <= is_div;
      cnt_q <= '0;
    end else if (step) begin
      hi_q  <= hi_c;
      lo_q  <= lo_c;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: FSM, single-cycle datapath and flag generation; MUL/DIV/MOD
// are delegated to the iterative muldiv unit.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  input  logic [OP_W-1:0] operation,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    y,
  output logic [N-1:0]    x,
  output logic            carryOutF,
  output logic            overflowF,
  output logic            negativeF,
  output logic            zeroF,
  output logic            errorF
);

  state_e          state;
  logic [OP_W-1:0] op_q;

  logic            multi_c;
  logic            md_load_c;
  logic            md_step_c;
  logic [N-1:0]    md_hi_c;
  logic [N-1:0]    md_lo_c;
  logic            md_last_c;

  logic [N:0]      add_s;
  logic [N:0]      sub_s;
  logic [N-1:0]    sc_y;
  logic [N-1:0]    sc_x;
  flags_t          sc_f;

  logic [N-1:0]    res_y;
  logic [N-1:0]    res_x;
  flags_t          res_f;

  assign multi_c   = is_iterative(operation, (b == '0));
  assign md_load_c = (state == S_IDLE) && start && multi_c;
  assign md_step_c = (state == S_RUN);

  seq_alu_muldiv #(.N(N)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (md_load_c),
    .is_div (operation != OP_MUL),
    .step   (md_step_c),
    .a      (a),
    .b      (b),
    .hi_c   (md_hi_c),
    .lo_c   (md_lo_c),
    .last_c (md_last_c)
  );

  // Single-cycle results, computed straight from the accepted inputs.
  always_comb begin
    sc_y  = '0;
    sc_x  = '0;
    sc_f  = '0;
    add_s = {1'b0, a} + {1'b0, b};
    sub_s = {1'b0, a} - {1'b0, b};
    case (operation)
      OP_AND: sc_y = a & b;
      OP_OR:  sc_y = a | b;
      OP_XOR: sc_y = a ^ b;
      OP_SHL: sc_y = (b >= N'(N)) ? '0 : (a << b);
      OP_SHR: sc_y = (b >= N'(N)) ? '0 : (a >> b);
      OP_ADD: begin
        sc_y       = add_s[N-1:0];
        sc_f.carry = add_s[N];
        sc_f.ovf   = (a[N-1] == b[N-1]) && (add_s[N-1] != a[N-1]);
      end
      OP_SUB: begin
        sc_y       = sub_s[N-1:0];
        sc_f.carry = ~sub_s[N];
        sc_f.ovf   = (a[N-1] != b[N-1]) && (sub_s[N-1] != a[N-1]);
      end
      OP_DIV, OP_MOD: begin
        sc_y     = '1;
        sc_x     = a;
        sc_f.err = 1'b1;
      end
      OP_MUL: sc_y = '0;
      default: sc_f.err = 1'b1;
    endcase
  end

  // Result selected for the DONE update: iterative unit while running, else single-cycle.
  always_comb begin
    res_y = sc_y;
    res_x = sc_x;
    res_f = sc_f;
    if (state == S_RUN) begin
      res_f = '0;
      case (op_q)
        OP_MUL: begin
          res_y       = md_lo_c;
          res_x       = md_hi_c;
          res_f.carry = |md_hi_c;
          res_f.ovf   = |md_hi_c;
        end
        OP_DIV: begin
          res_y = md_lo_c;
          res_x = md_hi_c;
        end
        default: begin
          res_y = md_hi_c;
          res_x = '0;
        end
      endcase
    end
    res_f.neg  = res_y[N-1];
    res_f.zero = (res_y == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      y         <= '0;
      x         <= '0;
      carryOutF <= 1'b0;
      overflowF <= 1'b0;
      negativeF <= 1'b0;
      zeroF     <= 1'b0;
      errorF    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= operation;
            if (multi_c) begin
              state <= S_RUN;
              busy  <= 1'b1;
            end else begin
              state     <= S_DONE;
              done      <= 1'b1;
              y         <= res_y;
              x         <= res_x;
              carryOutF <= res_f.carry;
              overflowF <= res_f.ovf;
              negativeF <= res_f.neg;
              zeroF     <= res_f.zero;
              errorF    <= res_f.err;
            end
          end
        end
        S_RUN: begin
          if (md_last_c) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            y         <= res_y;
            x         <= res_x;
            carryOutF <= res_f.carry;
            overflowF <= res_f.ovf;
            negativeF <= res_f.neg;
            zeroF     <= res_f.zero;
            errorF    <= res_f.err;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at N=4: driver queues expected results, a monitor
// checks each done pulse against the queue head.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   operation;
  logic         busy;
  logic         done;
  logic [N-1:0] y;
  logic [N-1:0] x;
  logic         carryOutF;
  logic         overflowF;
  logic         negativeF;
  logic         zeroF;
  logic         errorF;

  typedef struct {
    string        name;
    logic [N-1:0] y;
    logic [N-1:0] x;
    logic [4:0]   f;
    int unsigned  cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  seq_alu #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .operation (operation),
    .busy      (busy),
    .done      (done),
    .y         (y),
    .x         (x),
    .carryOutF (carryOutF),
    .overflowF (overflowF),
    .negativeF (negativeF),
    .zeroF     (zeroF),
    .errorF    (errorF)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done cycle=%0d y=%b x=%b", cyc, y, x);
      end else begin
        e = q.pop_front();
        tests++;
        if ({y, x, carryOutF, overflowF, negativeF, zeroF, errorF} !== {e.y, e.x, e.f}) begin
          fails++;
          $display("FAIL %s result: got y=%b x=%b cvnze=%b, want y=%b x=%b cvnze=%b",
                   e.name, y, x, {carryOutF, overflowF, negativeF, zeroF, errorF},
                   e.y, e.x, e.f);
        end
        tests++;
        if (cyc != e.cyc) begin
          fails++;
          $display("FAIL %s latency: done at cycle %0d, want %0d", e.name, cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input string name, input logic [3:0] op,
                       input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic [N-1:0] ey, input logic [N-1:0] ex,
                       input logic [4:0] ef, input bit multi, input bit poke);
    exp_t e;
    int   nb;
    bit   seen;
    @(negedge clk);
    e.name = name;
    e.y    = ey;
    e.x    = ex;
    e.f    = ef;
    e.cyc  = cyc + 1 + (multi ? N : 0);
    q.push_back(e);
    start     = 1'b1;
    a         = av;
    b         = bv;
    operation = op;
    @(negedge clk);
    start     = 1'b0;
    a         = ~av;
    b         = ~bv;
    operation = 4'd15;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < int'(N) + 4; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
      start = poke && (i == 1);
      @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s timeout: no done within %0d cycles", name, N + 4);
    end
    tests++;
    if (nb != (multi ? int'(N) : 0)) begin
      fails++;
      $display("FAIL %s busy_cycles: got %0d, want %0d", name, nb, multi ? N : 0);
    end
    @(negedge clk);
    tests++;
    if (y !== ey) begin
      fails++;
      $display("FAIL %s hold_y: got %b, want %b", name, y, ey);
    end
  endtask

  task automatic check_zero(input string name);
    tests++;
    if ({busy, done, y, x, carryOutF, overflowF, negativeF, zeroF, errorF} !== '0) begin
      fails++;
      $display("FAIL %s reset_outputs: got busy=%b done=%b y=%b x=%b cvnze=%b, want all 0",
               name, busy, done, y, x, {carryOutF, overflowF, negativeF, zeroF, errorF});
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    operation = '0;
    #2;
    check_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //    name        op      a        b        y        x        cvnze     multi poke
    issue("add_ovf",  OP_ADD, 4'b1010, 4'b1011, 4'b0101, 4'b0000, 5'b11000, 0, 0);
    issue("sub_neg",  OP_SUB, 4'b0001, 4'b0010, 4'b1111, 4'b0000, 5'b00100, 0, 0);
    issue("shl2",     OP_SHL, 4'b1110, 4'd2,    4'b1000, 4'b0000, 5'b00100, 0, 0);
    issue("mul_hi",   OP_MUL, 4'b1000, 4'b0100, 4'b0000, 4'b0010, 5'b11010, 1, 0);
    issue("div",      OP_DIV, 4'b1111, 4'b0110, 4'b0010, 4'b0011, 5'b00000, 1, 0);
    issue("mod",      OP_MOD, 4'b1111, 4'b0110, 4'b0011, 4'b0000, 5'b00000, 1, 0);
    issue("div0",     OP_DIV, 4'b1010, 4'b0000, 4'b1111, 4'b1010, 5'b00101, 0, 0);
    issue("illegal",  4'd15,  4'b1010, 4'b0101, 4'b0000, 4'b0000, 5'b00011, 0, 0);
    issue("and",      OP_AND, 4'b1100, 4'b1010, 4'b1000, 4'b0000, 5'b00100, 0, 0);
    issue("or",       OP_OR,  4'b0101, 4'b0010, 4'b0111, 4'b0000, 5'b00000, 0, 0);
    issue("xor_zero", OP_XOR, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 5'b00010, 0, 0);
    issue("shr3",     OP_SHR, 4'b1000, 4'd3,    4'b0001, 4'b0000, 5'b00000, 0, 0);
    issue("shl_big",  OP_SHL, 4'b1111, 4'd4,    4'b0000, 4'b0000, 5'b00010, 0, 0);
    issue("shr_big",  OP_SHR, 4'b1111, 4'd15,   4'b0000, 4'b0000, 5'b00010, 0, 0);
    issue("add_pov",  OP_ADD, 4'b0111, 4'b0001, 4'b1000, 4'b0000, 5'b01100, 0, 0);
    issue("sub_nov",  OP_SUB, 4'b1000, 4'b0001, 4'b0111, 4'b0000, 5'b11000, 0, 0);
    issue("mul_max",  OP_MUL, 4'b1111, 4'b1111, 4'b0001, 4'b1110, 5'b11000, 1, 0);
    issue("mul_lo",   OP_MUL, 4'b0011, 4'b0101, 4'b1111, 4'b0000, 5'b00100, 1, 0);
    issue("mod0",     OP_MOD, 4'b0111, 4'b0000, 4'b1111, 4'b0111, 5'b00101, 0, 0);
    issue("div_small",OP_DIV, 4'b0111, 4'b1000, 4'b0000, 4'b0111, 5'b00010, 1, 0);
    issue("mul_poke", OP_MUL, 4'b1000, 4'b0100, 4'b0000, 4'b0010, 5'b11010, 1, 1);
    repeat (N + 3) @(negedge clk);

    // Leave non-zero outputs behind, then abort a MUL with reset.
    issue("pre_rst",  OP_MUL, 4'b1111, 4'b1111, 4'b0001, 4'b1110, 5'b11000, 1, 0);
    @(negedge clk);
    start     = 1'b1;
    a         = 4'b0011;
    b         = 4'b0101;
    operation = OP_MUL;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 4) @(negedge clk);
    issue("post_rst", OP_MUL, 4'b0011, 4'b0101, 4'b1111, 4'b0000, 5'b00100, 1, 0);
    issue("post_add", OP_ADD, 4'b0011, 4'b0100, 4'b0111, 4'b0000, 5'b00000, 0, 0);
    repeat (3) @(negedge clk);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending: %0d expected results never seen, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
